// File: rtl/alu32_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu32_seq
//  Description : Sequencer wrapped around an external 32-bit ALU (alu32).
//                Two push buttons build the operands by incrementing (or
//                clearing, when clr is high) two 32-bit registers.
//                A start request launches one ALU operation and captures the
//                ALU output once the configured result latency has elapsed.
//
//  Parameters  : ALU_LAT          alu32 result latency in CLK cycles (1..15)
//                DEBOUNCE_CYCLES  consecutive equal samples needed before a
//                                 button level is accepted (20-bit counter);
//                                 used only when ALU32_SEQ_DEBOUNCE_EN is set
//
//  Macro       : ALU32_SEQ_DEBOUNCE_EN  defined   -> per-button debounce filter
//                                       undefined -> synchronized level used
//                                                    directly (default)
//
//  Ports       : CLK          in   system clock, rising-edge
//                rst_n        in   asynchronous active-low reset
//                pushButton1  in   raw operand-1 button, active-low, async
//                pushButton2  in   raw operand-2 button, active-low, async
//                clr          in   a press while high zeroes the operand
//                ALUop[2:0]   in   operation, sampled when start is accepted
//                start        in   execute request (level)
//                alu_result   in   output of the alu32 instance
//                alu_inp1     out  operand 1 to alu32
//                alu_inp2     out  operand 2 to alu32
//                alu_op[2:0]  out  operation to alu32
//                busy         out  high while an operation is in flight
//                done         out  one-cycle pulse when result is updated
//                result       out  captured ALU output
//
//  Revision    : 1.0  initial release
// ============================================================================
module alu32_seq #(
    parameter int ALU_LAT         = 1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        pushButton1,
    input  logic        pushButton2,
    input  logic        clr,
    input  logic [2:0]  ALUop,
    input  logic        start,
    input  logic [31:0] alu_result,
    output logic [31:0] alu_inp1,
    output logic [31:0] alu_inp2,
    output logic [2:0]  alu_op,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    // WAIT runs from ALU_LAT-1 down to 0, so it lasts exactly ALU_LAT cycles
    localparam logic [3:0] C_WAIT_LOAD = 4'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    // Out-of-range settings elaborate an empty g_cfg_error scope so a bad
    // configuration is visible in the elaborated hierarchy.
    if (ALU_LAT < 1 || ALU_LAT > 15 || DEBOUNCE_CYCLES < 1 ||
        DEBOUNCE_CYCLES > 1048575) begin : g_cfg_error
    end

    // ------------------------------------------------------------------
    // Button conditioning: bit 0 = pushButton1, bit 1 = pushButton2.
    // Buttons are active-low, so the idle (released) level is 1.
    // ------------------------------------------------------------------
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] w_level;
    logic [1:0] r_level_d;
    logic [1:0] r_press;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
        end else begin
            r_sync1 <= {pushButton2, pushButton1};
            r_sync2 <= r_sync1;
        end
    end

`ifdef ALU32_SEQ_DEBOUNCE_EN
    localparam logic [19:0] C_DEB_LAST = 20'(DEBOUNCE_CYCLES - 1);

    logic [19:0] r_deb_cnt [2];
    logic [1:0]  r_stable;

    // A new level is adopted only after DEBOUNCE_CYCLES consecutive samples
    // that differ from the currently accepted level; any sample equal to the
    // accepted level restarts the count, so short glitches never get through.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                r_deb_cnt[i] <= 20'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_deb_cnt[i] <= 20'd0;
                end else if (r_deb_cnt[i] == C_DEB_LAST) begin
                    r_stable[i]  <= r_sync2[i];
                    r_deb_cnt[i] <= 20'd0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 20'd1;
                end
            end
        end
    end

    assign w_level = r_stable;
`else
    assign w_level = r_sync2;
`endif

    // Falling edge of the conditioned level -> registered one-cycle strobe
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_level_d <= 2'b11;
            r_press   <= 2'b00;
        end else begin
            r_level_d <= w_level;
            r_press   <= r_level_d & ~w_level;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_capture;
    logic [3:0]  r_wait_cnt;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ISSUE;
                    w_accept    = 1'b1;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_state_nxt = S_IDLE;
                w_capture   = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 4'd0;
        end else if (r_state == S_ISSUE) begin
            r_wait_cnt <= C_WAIT_LOAD;
        end else if (r_state == S_WAIT && r_wait_cnt != 4'd0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Operand registers. Strobes arriving outside IDLE are dropped, which
    // freezes the operands for the whole execution. A strobe on the same
    // edge as start acceptance still lands, so ISSUE sees the new value.
    // ------------------------------------------------------------------
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [31:0] w_op1_nxt;
    logic [31:0] w_op2_nxt;
    logic        w_idle;

    assign w_idle    = (r_state == S_IDLE);
    assign w_op1_nxt = (w_idle && r_press[0]) ? (clr ? 32'd0 : r_op1 + 32'd1) : r_op1;
    assign w_op2_nxt = (w_idle && r_press[1]) ? (clr ? 32'd0 : r_op2 + 32'd1) : r_op2;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_op1 <= 32'd0;
            r_op2 <= 32'd0;
        end else begin
            r_op1 <= w_op1_nxt;
            r_op2 <= w_op2_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Operation select, result capture and done pulse
    // ------------------------------------------------------------------
    logic [2:0]  r_alu_op;
    logic [31:0] r_result;
    logic        r_done;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_op <= 3'd0;
            r_result <= 32'd0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_capture;
            if (w_accept) begin
                r_alu_op <= ALUop;
            end
            if (w_capture) begin
                r_result <= alu_result;
            end
        end
    end

    assign alu_inp1 = r_op1;
    assign alu_inp2 = r_op2;
    assign alu_op   = r_alu_op;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign result   = r_result;

endmodule
`default_nettype wire

// File: tb/tb_alu32_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu32_seq
//  Description : Self-checking bench for alu32_seq. A transaction-level model
//                (edge-stamped operations, sampled button history) predicts
//                every output each cycle; directed scenarios add literal
//                expectations on top of randomized stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu32_seq;

    localparam int LAT = 1;
`ifdef ALU32_SEQ_DEBOUNCE_EN
    localparam int DEB  = 8;
    localparam int HOLD = 14;
`else
    localparam int DEB  = 50000;
    localparam int HOLD = 3;
`endif

    logic        CLK   = 1'b0;
    logic        rst_n = 1'b1;
    logic        pb1   = 1'b1;
    logic        pb2   = 1'b1;
    logic        clr   = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  aluop = 3'd0;
    logic [31:0] alu_result;
    logic [31:0] inp1;
    logic [31:0] inp2;
    logic [2:0]  op;
    logic        busy;
    logic        done;
    logic [31:0] res;

    int n_chk    = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    always #5 CLK = ~CLK;

    alu32_seq #(
        .ALU_LAT         (LAT),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .pushButton1 (pb1),
        .pushButton2 (pb2),
        .clr         (clr),
        .ALUop       (aluop),
        .start       (start),
        .alu_result  (alu_result),
        .alu_inp1    (inp1),
        .alu_inp2    (inp2),
        .alu_op      (op),
        .busy        (busy),
        .done        (done),
        .result      (res)
    );

    function automatic logic [31:0] alu_f(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        case (o)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[4:0];
            3'd6:    return a >> b[4:0];
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Bench-side alu32: LAT-stage pipeline from the DUT's operand outputs
    logic [31:0] alu_pipe [LAT];
    always @(posedge CLK) begin
        alu_pipe[0] <= alu_f(op, inp1, inp2);
        for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_result = alu_pipe[LAT-1];

    // ---------------- behavioural model ----------------
    logic [31:0] m_op1 = 0, m_op2 = 0, m_res = 0;
    logic [2:0]  m_aluop = 0;
    logic        m_busy = 0, m_done = 0;
    logic [3:0]  m_h1 = 4'hF, m_h2 = 4'hF;   // raw button samples, [0] newest
    int          edge_n = 0, m_start_edge = 0;
    logic        ops_known = 1'b1;

    // A raw falling edge between samples k-1 and k updates the operand at
    // edge k+3 (if idle then). Operation started at edge N finishes at N+2+LAT.
    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            m_op1 = 0; m_op2 = 0; m_res = 0; m_aluop = 0;
            m_busy = 0; m_done = 0; m_h1 = 4'hF; m_h2 = 4'hF;
        end else begin
            edge_n = edge_n + 1;
            m_done = 1'b0;
            if (!m_busy) begin
`ifndef ALU32_SEQ_DEBOUNCE_EN
                if (m_h1[3] && !m_h1[2]) m_op1 = clr ? 32'd0 : m_op1 + 32'd1;
                if (m_h2[3] && !m_h2[2]) m_op2 = clr ? 32'd0 : m_op2 + 32'd1;
`endif
                if (start) begin
                    m_busy = 1'b1; m_start_edge = edge_n; m_aluop = aluop;
                end
            end else if (edge_n == m_start_edge + 2 + LAT) begin
                m_busy = 1'b0; m_done = 1'b1;
                m_res  = alu_f(m_aluop, m_op1, m_op2);
            end
            m_h1 = {m_h1[2:0], pb1};
            m_h2 = {m_h2[2:0], pb2};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare, away from the active edge
    always @(negedge CLK) begin
        if (done === 1'b1) done_cnt++;
        chk("busy",   {31'd0, busy}, {31'd0, m_busy});
        chk("done",   {31'd0, done}, {31'd0, m_done});
        chk("result", res, m_res);
        chk("alu_op", {29'd0, op}, {29'd0, m_aluop});
        if (ops_known) begin
            chk("alu_inp1", inp1, m_op1);
            chk("alu_inp2", inp2, m_op2);
        end
    end

    task automatic tick;
        @(negedge CLK);
        #2;
    endtask

    task automatic press(input int b);
`ifdef ALU32_SEQ_DEBOUNCE_EN
        ops_known = 1'b0;
`endif
        if (b == 1) pb1 = 1'b0; else pb2 = 1'b0;
        repeat (HOLD) tick;
        pb1 = 1'b1; pb2 = 1'b1;
        repeat (HOLD + 4) tick;
`ifdef ALU32_SEQ_DEBOUNCE_EN
        if (b == 1) m_op1 = clr ? 32'd0 : m_op1 + 32'd1;
        else        m_op2 = clr ? 32'd0 : m_op2 + 32'd1;
        ops_known = 1'b1;
`endif
    endtask

    // Loads both operand registers through their next-value nets
    logic [31:0] pre_a, pre_b;
    task automatic preload(input logic [31:0] a, input logic [31:0] b);
        tick;
        pre_a = a; pre_b = b;
        force dut.w_op1_nxt = pre_a;
        force dut.w_op2_nxt = pre_b;
        @(posedge CLK);
        #1;
        release dut.w_op1_nxt;
        release dut.w_op2_nxt;
        m_op1 = a; m_op2 = b;
    endtask

    int d0;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) tick;
        // reset state
        chk("rst_inp1", inp1, 32'd0);
        chk("rst_inp2", inp2, 32'd0);
        chk("rst_result", res, 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick;

        // three presses on button 1, one on button 2
        press(1); press(1); press(1); press(2);
        chk("presses_inp1", inp1, 32'd3);
        chk("presses_inp2", inp2, 32'd1);
        chk("model_op1", m_op1, 32'd3);

        // wrap at 2^32
        preload(32'hFFFF_FFFF, 32'd1);
        press(1);
        chk("wrap_inp1", inp1, 32'd0);
        chk("wrap_inp2", inp2, 32'd1);

        // one execution, AND of 0x1234 and all-ones
        preload(32'h0000_1234, 32'hFFFF_FFFF);
        tick; start = 1'b1; aluop = 3'b010;
        tick; start = 1'b0;
        chk("exe_busy0", {31'd0, busy}, 32'd1);
        chk("exe_aluop", {29'd0, op}, 32'd2);
        tick; chk("exe_busy1", {31'd0, busy}, 32'd1);
        tick; chk("exe_busy2", {31'd0, busy}, 32'd1);
        chk("exe_done_early", {31'd0, done}, 32'd0);
        tick; chk("exe_busy_end", {31'd0, busy}, 32'd0);
        chk("exe_done", {31'd0, done}, 32'd1);
        chk("exe_result", res, 32'h0000_1234);
        chk("model_res", m_res, 32'h0000_1234);
        tick; chk("exe_done_pulse", {31'd0, done}, 32'd0);

        // press and repeated start while busy
        d0 = done_cnt;
        tick; start = 1'b1; pb1 = 1'b0;
        tick; chk("busy_blk_busy", {31'd0, busy}, 32'd1);
        tick; pb1 = 1'b1;
        tick; start = 1'b0;
        repeat (8) tick;
        chk("busy_blk_once", done_cnt - d0, 32'd1);
        chk("busy_blk_inp1", inp1, 32'h0000_1234);
        chk("busy_blk_inp2", inp2, 32'hFFFF_FFFF);

        // reset during WAIT
        tick; start = 1'b1;
        tick; start = 1'b0;
        tick; rst_n = 1'b0;
        #1;
        chk("abort_busy_done", {30'd0, busy, done}, 32'd0);
        chk("abort_result", res, 32'd0);
        chk("abort_inp", inp1 | inp2 | {29'd0, op}, 32'd0);
        d0 = done_cnt;
        tick; rst_n = 1'b1;
        repeat (6) tick;
        chk("abort_no_done", done_cnt - d0, 32'd0);

`ifdef ALU32_SEQ_DEBOUNCE_EN
        ops_known = 1'b0;
        pb1 = 1'b0; repeat (5) tick; pb1 = 1'b1; repeat (20) tick;
        chk("glitch_ignored", inp1, 32'd0);
        pb1 = 1'b0; repeat (12) tick; pb1 = 1'b1; repeat (20) tick;
        chk("long_press", inp1, 32'd1);
        m_op1 = 32'd1;
        ops_known = 1'b1;
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick;
            start = ($urandom % 4) == 0;
            aluop = 3'($urandom);
            clr   = ($urandom % 6) == 0;
`ifndef ALU32_SEQ_DEBOUNCE_EN
            if (($urandom % 5) == 0) pb1 = ~pb1;
            if (($urandom % 5) == 0) pb2 = ~pb2;
`endif
            if (i == 1500) rst_n = 1'b0;
            if (i == 1502) rst_n = 1'b1;
        end
        start = 1'b0; pb1 = 1'b1; pb2 = 1'b1;
        repeat (10) tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
